flood_win_scan: RTL and testbench



---
 rtl/flood_pkg.sv | 32 +++
 rtl/board_cell_sel.sv | 17 +
 rtl/flood_win_scan.sv | 157 +++++++++++++++
 tb/tb_flood_win_scan.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flood_pkg.sv
// Shared constants, colour/state types and the flat-board cell addressing helper
// for the Flood-It datapath.
package flood_pkg;

    localparam int MAX_SIZE = 26;
    localparam int COLOR_W  = 3;
    localparam int BOARD_W  = MAX_SIZE * MAX_SIZE * COLOR_W;
    localparam int DIM_W    = 5;
    localparam int CNT_W    = 10;

    typedef enum logic [2:0] {
        COLOR_RED    = 3'd0,
        COLOR_GREEN  = 3'd1,
        COLOR_BLUE   = 3'd2,
        COLOR_YELLOW = 3'd3
    } color_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } scan_state_e;

    // Bit offset of cell (row, col) in a row-major flattened board.
    function automatic int cell_offset(input logic [DIM_W-1:0] row,
                                       input logic [DIM_W-1:0] col,
                                       input int max_size,
                                       input int color_w);
        return ((int'(row) * max_size) + int'(col)) * color_w;
    endfunction

endpackage

// File: rtl/board_cell_sel.sv
// Combinational read mux: returns the colour of cell (row, col) from the flat board bus.
module board_cell_sel #(
    parameter int MAX_SIZE = flood_pkg::MAX_SIZE,
    parameter int COLOR_W  = flood_pkg::COLOR_W
) (
    input  logic [MAX_SIZE*MAX_SIZE*COLOR_W-1:0] board_i,
    input  logic [4:0]                           row_i,
    input  logic [4:0]                           col_i,
    output logic [COLOR_W-1:0]                   cell_o
);
    import flood_pkg::*;

    always_comb begin
        cell_o = board_i[cell_offset(row_i, col_i, MAX_SIZE, COLOR_W) +: COLOR_W];
    end

endmodule

// File: rtl/flood_win_scan.sv
// Walks the active SIZE x SIZE board region one cell per cycle, counting cells that
// match the flood-origin colour, and reports a win when every active cell matches.
module flood_win_scan #(
    parameter int MAX_SIZE = flood_pkg::MAX_SIZE,
    parameter int COLOR_W  = flood_pkg::COLOR_W
) (
    input  logic                                 CLOCK,
    input  logic                                 RESET,
    input  logic                                 START,
    input  logic [MAX_SIZE*MAX_SIZE*COLOR_W-1:0] BOARD,
    input  logic [4:0]                           SIZE,
    output logic                                 BUSY,
    output logic                                 DONE,
    output logic                                 WIN,
    output logic [9:0]                           MATCH_COUNT,
    output logic [1:0]                           STATE_DBG
);
    import flood_pkg::*;

    // Handshake: START is a request that is taken only on a cycle where the block is
    // IDLE; BUSY is high while cells are being read; DONE pulses for exactly one cycle
    // when WIN/MATCH_COUNT become valid, and those results hold until the next taken START.

    localparam logic [4:0] MAX_DIM = 5'(MAX_SIZE);

    scan_state_e          state_q, state_d;
    logic [4:0]           n_eff_q, n_eff_d;
    logic [4:0]           row_q, row_d;
    logic [4:0]           col_q, col_d;
    logic [9:0]           count_q, count_d;
    logic [9:0]           match_q, match_d;
    logic [COLOR_W-1:0]   ref_q, ref_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 win_q, win_d;

    logic [COLOR_W-1:0]   origin_cell;
    logic [COLOR_W-1:0]   scan_cell;
    logic [4:0]           size_clamped;
    logic [9:0]           n_sq;
    logic [9:0]           count_inc;
    logic                 last_col;
    logic                 last_cell;

    board_cell_sel #(.MAX_SIZE(MAX_SIZE), .COLOR_W(COLOR_W)) u_origin_sel (
        .board_i (BOARD),
        .row_i   (5'd0),
        .col_i   (5'd0),
        .cell_o  (origin_cell)
    );

    board_cell_sel #(.MAX_SIZE(MAX_SIZE), .COLOR_W(COLOR_W)) u_scan_sel (
        .board_i (BOARD),
        .row_i   (row_q),
        .col_i   (col_q),
        .cell_o  (scan_cell)
    );

    always_comb begin
        if (SIZE <= 5'd1) begin
            size_clamped = 5'd1;
        end else if (SIZE > MAX_DIM) begin
            size_clamped = MAX_DIM;
        end else begin
            size_clamped = SIZE;
        end
    end

    assign n_sq      = 10'(n_eff_q) * 10'(n_eff_q);
    assign count_inc = count_q + {9'd0, (scan_cell == ref_q)};
    assign last_col  = (col_q == n_eff_q - 5'd1);
    assign last_cell = last_col && (row_q == n_eff_q - 5'd1);

    always_comb begin
        state_d = state_q;
        n_eff_d = n_eff_q;
        row_d   = row_q;
        col_d   = col_q;
        count_d = count_q;
        match_d = match_q;
        ref_d   = ref_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        win_d   = win_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    n_eff_d = size_clamped;
                    ref_d   = origin_cell;
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                    count_d = 10'd0;
                    match_d = 10'd0;
                    win_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                count_d = count_inc;
                if (last_cell) begin
                    // Results are registered here so they are visible during FINISH.
                    match_d = count_inc;
                    win_d   = (count_inc == n_sq);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FINISH;
                end else if (last_col) begin
                    col_d = 5'd0;
                    row_d = row_q + 5'd1;
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            n_eff_q <= 5'd0;
            row_q   <= 5'd0;
            col_q   <= 5'd0;
            count_q <= 10'd0;
            match_q <= 10'd0;
            ref_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_eff_q <= n_eff_d;
            row_q   <= row_d;
            col_q   <= col_d;
            count_q <= count_d;
            match_q <= match_d;
            ref_q   <= ref_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign WIN         = win_q;
    assign MATCH_COUNT = match_q;
    assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_flood_win_scan.sv
// Self-checking bench for flood_win_scan: directed vector table, multi-cycle corner
// sequences and randomized boards checked against a cell-counting reference model.
module tb_flood_win_scan;

    localparam int MS = 26;
    localparam int CW = 3;

    logic             clk;
    logic             rst;
    logic             start;
    logic [MS*MS*CW-1:0] board;
    logic [4:0]       size;
    logic             busy;
    logic             done;
    logic             win;
    logic [9:0]       match_count;
    logic [1:0]       state_dbg;

    logic [CW-1:0]    bd [0:MS-1][0:MS-1];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int size;
        int pat;
        int exp_mc;
        int exp_win;
        int exp_lat;
    } vec_t;

    vec_t vecs [7];

    flood_win_scan #(.MAX_SIZE(MS), .COLOR_W(CW)) dut (
        .CLOCK       (clk),
        .RESET       (rst),
        .START       (start),
        .BOARD       (board),
        .SIZE        (size),
        .BUSY        (busy),
        .DONE        (done),
        .WIN         (win),
        .MATCH_COUNT (match_count),
        .STATE_DBG   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pack_board();
        for (int r = 0; r < MS; r++)
            for (int c = 0; c < MS; c++)
                board[(r*MS+c)*CW +: CW] = bd[r][c];
    endtask

    task automatic fill_uniform(input int col);
        for (int r = 0; r < MS; r++)
            for (int c = 0; c < MS; c++)
                bd[r][c] = CW'(col);
        pack_board();
    endtask

    task automatic fill_random(input int max_col);
        for (int r = 0; r < MS; r++)
            for (int c = 0; c < MS; c++)
                bd[r][c] = CW'($urandom_range(0, max_col));
        pack_board();
    endtask

    // Uniform colour inside the n x n region, arbitrary colours outside it.
    task automatic fill_region(input int n, input int col);
        for (int r = 0; r < MS; r++)
            for (int c = 0; c < MS; c++)
                bd[r][c] = (r < n && c < n) ? CW'(col) : CW'($urandom_range(0, 7));
        pack_board();
    endtask

    task automatic fill_pattern(input int pat);
        case (pat)
            0: fill_uniform(2);
            1: begin
                fill_region(26, 1);
                fill_random(7);
                for (int r = 0; r < MS; r++)
                    for (int c = 0; c < MS; c++)
                        bd[r][c] = (r < 4 && c < 4) ? CW'(1) : bd[r][c];
                bd[3][3] = CW'(0);
                pack_board();
            end
            2: begin
                for (int r = 0; r < MS; r++)
                    for (int c = 0; c < MS; c++)
                        bd[r][c] = CW'((r + c) % 2);
                pack_board();
            end
            4: begin
                fill_uniform(1);
                bd[3][3] = CW'(0);
                pack_board();
            end
            default: fill_random(7);
        endcase
    endtask

    function automatic int model_n(input int sz);
        if (sz <= 1) return 1;
        if (sz > MS) return MS;
        return sz;
    endfunction

    function automatic int model_count(input int sz);
        int n;
        int cnt;
        n = model_n(sz);
        cnt = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                if (bd[r][c] == bd[0][0]) cnt++;
        return cnt;
    endfunction

    // Pulses START for one edge (cycle 0) and watches cycles 1.. until DONE.
    task automatic run_scan(input int sz, output int lat, output int busy_n,
                            output int mc, output int w);
        lat = -1;
        busy_n = 0;
        mc = 0;
        w = 0;
        @(negedge clk);
        size = 5'(sz);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = k;
                mc = int'(match_count);
                w = int'(win);
                break;
            end
        end
        if (lat >= 0) begin
            @(negedge clk);
            check("done_single_pulse", int'(done), 0);
        end
    endtask

    initial begin
        int lat, busy_n, mc, w, n, exp_cnt, done_cnt, done_at;

        vecs[0] = '{size: 4,  pat: 0, exp_mc: 16,  exp_win: 1, exp_lat: 17};
        vecs[1] = '{size: 4,  pat: 1, exp_mc: 15,  exp_win: 0, exp_lat: 17};
        vecs[2] = '{size: 30, pat: 0, exp_mc: 676, exp_win: 1, exp_lat: 677};
        vecs[3] = '{size: 0,  pat: 3, exp_mc: 1,   exp_win: 1, exp_lat: 2};
        vecs[4] = '{size: 1,  pat: 3, exp_mc: 1,   exp_win: 1, exp_lat: 2};
        vecs[5] = '{size: 26, pat: 4, exp_mc: 675, exp_win: 0, exp_lat: 677};
        vecs[6] = '{size: 5,  pat: 2, exp_mc: 13,  exp_win: 0, exp_lat: 26};

        rst = 1'b1;
        start = 1'b0;
        size = 5'd0;
        board = '0;
        fill_uniform(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_win", int'(win), 0);
        check("reset_match", int'(match_count), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            fill_pattern(vecs[i].pat);
            run_scan(vecs[i].size, lat, busy_n, mc, w);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].exp_lat - 1);
            check($sformatf("vec%0d_match", i), mc, vecs[i].exp_mc);
            check($sformatf("vec%0d_win", i), w, vecs[i].exp_win);
        end

        // Results from the checkerboard scan must hold while idle, whatever BOARD does.
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("hold_match", int'(match_count), 13);
            check("hold_win", int'(win), 0);
            if (k % 10 == 0) fill_random(7);
        end

        // A START during SCAN is ignored; a START right after FINISH is taken.
        fill_uniform(2);
        @(negedge clk);
        size = 5'd4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cnt = 0;
        done_at = -1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == 18) begin
                check("restart_pre_win", int'(win), 1);
                check("restart_pre_match", int'(match_count), 16);
            end
            if (k == 19) begin
                check("restart_win_cleared", int'(win), 0);
                check("restart_match_cleared", int'(match_count), 0);
                check("restart_busy", int'(busy), 1);
            end
            start = (k == 5 || k == 18);
        end
        start = 1'b0;
        check("ignored_start_done_count", done_cnt, 1);
        check("ignored_start_done_cycle", done_at, 17);
        done_at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                done_at = k;
                break;
            end
        end
        check("restart_finished", int'(done_at >= 0), 1);
        check("restart_result", int'(match_count), 16);

        // Reset in the middle of a SIZE=6 scan.
        fill_uniform(3);
        @(negedge clk);
        size = 5'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_win", int'(win), 0);
        check("midreset_match", int'(match_count), 0);
        check("midreset_state", int'(state_dbg), 0);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midreset_no_done", done_cnt, 0);
        run_scan(6, lat, busy_n, mc, w);
        check("after_reset_latency", lat, 37);
        check("after_reset_match", mc, 36);
        check("after_reset_win", w, 1);

        // START coinciding with RESET is dropped.
        @(negedge clk);
        size = 5'd4;
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        check("start_with_reset_busy", int'(busy), 0);
        @(negedge clk);
        check("start_with_reset_idle", int'(busy), 0);

        // Randomized boards against the reference model.
        for (int it = 0; it < 16; it++) begin
            int sz;
            int mode;
            sz = $urandom_range(0, 31);
            mode = $urandom_range(0, 3);
            n = model_n(sz);
            if (mode == 0) fill_region(n, $urandom_range(0, 7));
            else fill_random($urandom_range(1, 7));
            exp_cnt = model_count(sz);
            run_scan(sz, lat, busy_n, mc, w);
            check($sformatf("rand%0d_sz%0d_latency", it, sz), lat, n * n + 1);
            check($sformatf("rand%0d_sz%0d_match", it, sz), mc, exp_cnt);
            check($sformatf("rand%0d_sz%0d_win", it, sz), w, int'(exp_cnt == n * n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
